// File: rtl/alu_result_stage.sv
// alu_result_stage: one-entry register between the ALU and writeback.
// Holds the ALU result and destination tag behind a valid/ready handshake,
// keeps the architectural NZCV flags, and evaluates ARM condition codes
// against those committed flags.
module alu_result_stage #(
  parameter int          DATA_W    = 32,
  parameter int          TAG_W     = 4,
  parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_neg,
  input  logic              alu_zero,
  input  logic              alu_c_out,
  input  logic              alu_ovfl,
  input  logic [TAG_W-1:0]  in_rd,
  input  logic              in_wr_en,
  input  logic              in_set_nz,
  input  logic              in_set_cv,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_rd,
  output logic              out_wr_en,
  output logic [3:0]        flags,
  output logic              alu_c_in,
  input  logic [3:0]        cond,
  output logic              cond_pass
);

  logic accept;
  logic drain;
  logic flag_n;
  logic flag_z;
  logic flag_c;
  logic flag_v;

  // Handshake: the entry can be replaced whenever it is empty or leaving.
  always_comb begin
    in_ready = !out_valid || out_ready;
    accept   = in_valid && in_ready;
    drain    = out_valid && out_ready;
  end

  // Entry register: flush wins over accept; data is only loaded for accepts
  // that survive, so a flushed op leaves the previous payload untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rd    <= '0;
      out_wr_en <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (accept && !flush) begin
        out_data  <= alu_out;
        out_rd    <= in_rd;
        out_wr_en <= in_wr_en;
      end
    end
  end

  // Flags commit in accept order, even for ops whose data is flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= FLAGS_RST;
    end else if (accept) begin
      if (in_set_nz) begin
        flags[3] <= alu_neg;
        flags[2] <= alu_zero;
      end
      if (in_set_cv) begin
        flags[1] <= alu_c_out;
        flags[0] <= alu_ovfl;
      end
    end
  end

  // Carry feedback and individual flag views from the registered flags only.
  always_comb begin
    alu_c_in = flags[1];
    flag_n   = flags[3];
    flag_z   = flags[2];
    flag_c   = flags[1];
    flag_v   = flags[0];
  end

  // ARM condition code evaluation; no bypass from flags being written now.
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = !flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = !flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = !flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = !flag_v;
      4'h8: cond_pass = flag_c && !flag_z;
      4'h9: cond_pass = !flag_c || flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = !flag_z && (flag_n == flag_v);
      4'hD: cond_pass = flag_z || (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

endmodule
